// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment display controller with a small bus slave:
// a DATA register of hex nibbles and a CTRL register for enable, blink and decimal points.
module seven_seg_scan_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h6000_0000,
  parameter int          NUM_DIGITS   = 4,
  parameter int          SCAN_DIV     = 50000,
  parameter int          BLINK_ROUNDS = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PS_W  = $clog2(SCAN_DIV);
  localparam int RND_W = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;

  localparam logic [31:0]      DATA_ADDR = BASE_ADDR;
  localparam logic [31:0]      CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(BLINK_ROUNDS - 1);

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic                  data_sel_s;
  logic                  ctrl_sel_s;
  logic                  wr_data_s;
  logic                  wr_ctrl_s;
  logic                  rd_s;
  logic [31:0]           ctrl_rd_s;
  logic [31:0]           rd_mux_s;
  logic                  ps_wrap_s;
  logic                  idx_wrap_s;
  logic [4:0]            nib_lsb_s;
  logic [3:0]            nibble_s;
  logic [2:0]            dp_sel_s;
  logic                  dp_s;
  logic                  blank_s;

  logic [31:0]           data_r;
  logic                  disp_en_r;
  logic                  blink_en_r;
  logic [7:0]            dp_mask_r;
  logic [31:0]           rdata_r;
  logic [PS_W-1:0]       ps_r;
  logic [IDX_W-1:0]      idx_r;
  logic [RND_W-1:0]      round_r;
  logic                  phase_r;
  logic [7:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;

  // Address decode, read mux, scan wrap detection and current-digit selection.
  always_comb begin
    data_sel_s = (addr_i == DATA_ADDR);
    ctrl_sel_s = (addr_i == CTRL_ADDR);
    wr_data_s  = en_i & we_i & data_sel_s;
    wr_ctrl_s  = en_i & we_i & ctrl_sel_s;
    rd_s       = en_i & re_i;
    ctrl_rd_s  = {16'h0000, dp_mask_r, 6'b000000, blink_en_r, disp_en_r};
    if (data_sel_s) begin
      rd_mux_s = data_r;
    end else if (ctrl_sel_s) begin
      rd_mux_s = ctrl_rd_s;
    end else begin
      rd_mux_s = 32'h0000_0000;
    end
    ps_wrap_s  = (ps_r == PS_LAST);
    idx_wrap_s = ps_wrap_s && (idx_r == IDX_LAST);
    nib_lsb_s  = 5'({idx_r, 2'b00});
    nibble_s   = data_r[nib_lsb_s +: 4];
    dp_sel_s   = 3'(idx_r);
    dp_s       = ~dp_mask_r[dp_sel_s];
    blank_s    = ~disp_en_r | (blink_en_r & ~phase_r);
  end

  // Register file and registered read port; a read sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_r     <= 32'h0000_0000;
      disp_en_r  <= 1'b0;
      blink_en_r <= 1'b0;
      dp_mask_r  <= 8'h00;
      rdata_r    <= 32'h0000_0000;
    end else begin
      if (wr_data_s) begin
        data_r <= wdata_i;
      end
      if (wr_ctrl_s) begin
        disp_en_r  <= wdata_i[0];
        blink_en_r <= wdata_i[1];
        dp_mask_r  <= wdata_i[15:8];
      end
      if (rd_s) begin
        rdata_r <= rd_mux_s;
      end
    end
  end

  // Prescaler, digit index, round counter and blink phase.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ps_r    <= {PS_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      round_r <= {RND_W{1'b0}};
      phase_r <= 1'b1;
    end else begin
      if (ps_wrap_s) begin
        ps_r <= {PS_W{1'b0}};
        if (idx_wrap_s) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        ps_r <= ps_r + PS_W'(1);
      end
      // A CTRL write restarts the blink cycle in the visible phase.
      if (wr_ctrl_s) begin
        round_r <= {RND_W{1'b0}};
        phase_r <= 1'b1;
      end else if (idx_wrap_s) begin
        if (round_r == RND_LAST) begin
          round_r <= {RND_W{1'b0}};
          phase_r <= ~phase_r;
        end else begin
          round_r <= round_r + RND_W'(1);
        end
      end
    end
  end

  // Registered segment and anode drive.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_r <= 8'hFF;
      an_r  <= {NUM_DIGITS{1'b1}};
    end else if (blank_s) begin
      seg_r <= 8'hFF;
      an_r  <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r <= {dp_s, hex_to_seg(nibble_s)};
      an_r  <= ~(NUM_DIGITS'(1'b1) << idx_r);
    end
  end

  assign rdata_o = rdata_r;
  assign seg_o   = seg_r;
  assign an_o    = an_r;

endmodule
